openhw_clint_apb: RTL and testbench
===================================

// Module: openhw_clint_apb
// PURPOSE
// Core-local interruptor: the source end of the machine timer/software interrupt path into the privileged unit.
// Holds mtime, mtimecmp and msip behind an APB slave port on the uncore bus.
// Drives MTimerInt, MSwInt and MTIME_CLINT to the hart's CSR/trap logic.
// Single-hart instance.
// PARAMETERS
// XLEN      32/64  APB data width; selects 32-bit split or 64-bit whole-register access
// TIMEDIV   1      mtime increments once every TIMEDIV clk cycles (1..65535)
// ADRBITS   16     PADDR width; decode uses PADDR[15:0]
// PORTS
// clk          in   1          clock
// reset_n      in   1          asynchronous, active-low reset
// PSEL         in   1          APB select
// PENABLE      in   1          APB access phase
// PWRITE       in   1          1=write, 0=read
// PADDR        in   ADRBITS    byte address
// PWDATA       in   XLEN       write data
// PSTRB        in   XLEN/8     byte write enables
// PRDATA       out  XLEN       read data
// PREADY       out  1          transfer complete
// PSLVERR      out  1          unmapped access
// MTIME_CLINT  out  64         current mtime
// MTimerInt    out  1          machine timer interrupt pending
// MSwInt       out  1          machine software interrupt pending
// BEHAVIOUR
// - Reset state (reset_n low, async): mtime=0, mtimecmp=all ones, msip=0, prescaler=0.
//   Outputs while reset_n is low: PRDATA=0, PREADY=0, PSLVERR=0, MTimerInt=0, MSwInt=0, MTIME_CLINT=0.
// - Map:
//   - 0x0000 msip: bit0 is RW, other bits read 0.
//   - 0x4000 mtimecmp.
//   - 0xBFF8 mtime.
//   - XLEN=32: +0 selects the low word, +4 the high word (PADDR[2]).
//   - XLEN=64: PADDR[2:0] ignored; access is whole 64 bits.
// - APB, zero wait states:
//   - PREADY = PSEL & PENABLE.
//   - PRDATA is registered at the end of setup (PSEL & ~PENABLE), so it is valid during access. PRDATA holds otherwise.
//   - Writes commit on the clk edge ending access (PSEL & PENABLE & PWRITE). Only bytes with PSTRB set are written.
// - Unmapped address:
//   - Read returns 0 and PSLVERR=1 during access.
//   - Write is dropped and PSLVERR=1.
//   - PSLVERR is 0 for mapped addresses.
// - Prescaler:
//   - Counts 0..TIMEDIV-1 and wraps.
//   - mtime += 1 (64-bit wrap 0xFFFF_FFFF_FFFF_FFFF -> 0) on the cycle the prescaler wraps.
//   - TIMEDIV=1 means mtime increments every cycle.
// - APB write to any mtime byte in a cycle:
//   - The written value is loaded.
//   - The increment is suppressed for the whole 64 bits in that cycle (no carry into an unwritten half).
//   - The prescaler resets to 0.
// - MTIME_CLINT = mtime register (no extra latency).
// - MTimerInt is registered from (mtime >= mtimecmp), unsigned 64-bit, using the register values of the current cycle.
//   - So it asserts 1 cycle after the compare becomes true.
//   - It deasserts 1 cycle after a mtimecmp or mtime write makes the compare false.
// - MSwInt = msip bit0 (registered; visible the cycle after the write).
// - A read of a register in the same transfer that would see a prescaler increment returns the pre-increment value.
// - PSEL dropped mid-transfer (PENABLE without a setup phase): treated as access. PRDATA is stale; the write still commits.
// - reset_n asserted mid-transfer: all state returns to reset values immediately. The transfer is lost; no partial write.
// TESTING
// 1. Release reset, TIMEDIV=1, idle 10 cycles -> MTIME_CLINT=10, MTimerInt=0, MSwInt=0.
// 2. Write mtimecmp=20 (XLEN=64) while mtime=5 -> MTimerInt rises exactly 1 cycle after mtime reaches 20.
//    Then write mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> MTimerInt falls 1 cycle after the write.
// 3. XLEN=32: write mtime low=0xFFFF_FFFF, then high=0 -> after 1 idle cycle mtime=0x1_0000_0000 (carry crosses halves).
//    Read +4 -> 1.
// 4. Write msip PWDATA=0xFFFF_FFFF, PSTRB all set -> MSwInt=1 next cycle; readback=0x1.
//    Write PSTRB=0 -> msip unchanged.
// 5. TIMEDIV=4: mtime increments every 4th cycle.
//    Write mtime=100 mid-interval -> next increment to 101 occurs 4 cycles after the write.
// 6. Read 0x2000 -> PRDATA=0, PSLVERR=1, PREADY=1.
//    Assert reset_n=0 during a mtimecmp write access -> mtimecmp reads all ones after reset.

Source files
------------

// File: rtl/openhw_clint_apb.sv
// Single-hart core-local interruptor: mtime, mtimecmp and msip behind an APB slave,
// driving the machine timer/software interrupt lines into the privileged unit.
module openhw_clint_apb #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEDIV = 1,
  parameter int unsigned ADRBITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADRBITS-1:0]   PADDR,
  input  logic [XLEN-1:0]      PWDATA,
  input  logic [XLEN/8-1:0]    PSTRB,
  output logic [XLEN-1:0]      PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [63:0]          MTIME_CLINT,
  output logic                 MTimerInt,
  output logic                 MSwInt
);

  localparam logic [15:0] PreMax = 16'(TIMEDIV - 1);

  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic [15:0] prescaler;

  logic        selMsip, selCmp, selTime, mapped;
  logic        access, wrEn, timeWr, wrap;
  logic [63:0] wdata64, rdata64, byteMask, mtimeMerged;
  logic [7:0]  strb8;
  logic [XLEN-1:0] rdNext;
  logic        unusedAddr;

  assign selMsip = (PADDR[15:3] == 13'h0000);
  assign selCmp  = (PADDR[15:3] == 13'h0800);
  assign selTime = (PADDR[15:3] == 13'h17FF);
  assign mapped  = selMsip | selCmp | selTime;
  assign unusedAddr = ^PADDR;

  // Both widths are folded onto a 64-bit data path with a per-byte strobe.
  if (XLEN == 64) begin : gWide
    assign wdata64 = PWDATA;
    assign strb8   = PSTRB;
    assign rdNext  = rdata64;
  end else begin : gSplit
    assign wdata64 = {PWDATA, PWDATA};
    assign strb8   = PADDR[2] ? {PSTRB, 4'h0} : {4'h0, PSTRB};
    assign rdNext  = PADDR[2] ? rdata64[63:32] : rdata64[31:0];
  end

  always_comb begin
    byteMask = '0;
    for (int b = 0; b < 8; b++) begin
      byteMask[8*b +: 8] = {8{strb8[b]}};
    end
  end

  always_comb begin
    rdata64 = '0;
    if (selMsip)      rdata64 = {63'b0, msip};
    else if (selCmp)  rdata64 = mtimecmp;
    else if (selTime) rdata64 = mtime;
  end

  assign access      = PSEL & PENABLE;
  assign wrEn        = access & PWRITE & mapped;
  assign timeWr      = wrEn & selTime & (|strb8);
  assign wrap        = (prescaler == PreMax);
  assign mtimeMerged = (mtime & ~byteMask) | (wdata64 & byteMask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      prescaler <= '0;
      PRDATA    <= '0;
      MTimerInt <= 1'b0;
    end else begin
      if (PSEL && !PENABLE) PRDATA <= rdNext;
      MTimerInt <= (mtime >= mtimecmp);
      if (wrEn && selMsip && strb8[0]) msip <= wdata64[0];
      if (wrEn && selCmp) mtimecmp <= (mtimecmp & ~byteMask) | (wdata64 & byteMask);
      // A software write owns all 64 bits this cycle and restarts the prescale interval.
      if (timeWr) begin
        mtime     <= mtimeMerged;
        prescaler <= '0;
      end else if (wrap) begin
        mtime     <= mtime + 64'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

  assign PREADY      = access & reset_n;
  assign PSLVERR     = access & reset_n & ~mapped;
  assign MTIME_CLINT = mtime;
  assign MSwInt      = msip;

endmodule

// File: tb/tb_openhw_clint_apb.sv
// Bench for openhw_clint_apb: a 64-bit/TIMEDIV=1 instance and a 32-bit/TIMEDIV=4 instance
// checked against a time-based register model.
module tb_openhw_clint_apb;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic        pselA, penA, pwrA, preadyA, pslverrA, tintA, swA;
  logic [15:0] paddrA;
  logic [63:0] pwdataA, prdataA, mtimeA;
  logic [7:0]  pstrbA;

  logic        pselB, penB, pwrB, preadyB, pslverrB, tintB, swB;
  logic [15:0] paddrB;
  logic [31:0] pwdataB, prdataB;
  logic [63:0] mtimeB;
  logic [3:0]  pstrbB;

  openhw_clint_apb #(.XLEN(64), .TIMEDIV(1), .ADRBITS(16)) dutA (
    .clk(clk), .reset_n(rstN), .PSEL(pselA), .PENABLE(penA), .PWRITE(pwrA), .PADDR(paddrA),
    .PWDATA(pwdataA), .PSTRB(pstrbA), .PRDATA(prdataA), .PREADY(preadyA), .PSLVERR(pslverrA),
    .MTIME_CLINT(mtimeA), .MTimerInt(tintA), .MSwInt(swA)
  );

  openhw_clint_apb #(.XLEN(32), .TIMEDIV(4), .ADRBITS(16)) dutB (
    .clk(clk), .reset_n(rstN), .PSEL(pselB), .PENABLE(penB), .PWRITE(pwrB), .PADDR(paddrB),
    .PWDATA(pwdataB), .PSTRB(pstrbB), .PRDATA(prdataB), .PREADY(preadyB), .PSLVERR(pslverrB),
    .MTIME_CLINT(mtimeB), .MTimerInt(tintB), .MSwInt(swB)
  );

  // Model: mtime = last written value + elapsed cycles / TIMEDIV.
  logic [63:0] baseM [2];
  logic [63:0] cmpM [2];
  int unsigned baseCyc [2];
  bit          msipM [2];
  bit          expIrq [2];
  int unsigned cyc = 0;
  int          nVec = 0;
  int          nErr = 0;

  function automatic logic [63:0] modelMtime(input int i);
    int unsigned div = (i == 0) ? 1 : 4;
    return baseM[i] + 64'((cyc - baseCyc[i]) / div);
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      expIrq[0] <= 1'b0;
      expIrq[1] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) expIrq[i] <= (modelMtime(i) >= cmpM[i]);
      cyc <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      baseM[i]   = '0;
      baseCyc[i] = cyc;
      cmpM[i]    = '1;
      msipM[i]   = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check("mtimeA", mtimeA, modelMtime(0));
      check("mtimeB", mtimeB, modelMtime(1));
      check("tintA", 64'(tintA), 64'(expIrq[0]));
      check("tintB", 64'(tintB), 64'(expIrq[1]));
      check("swA", 64'(swA), 64'(msipM[0]));
      check("swB", 64'(swB), 64'(msipM[1]));
    end
  endtask

  task automatic drive(input int i, input bit sel, input bit en, input bit wr,
                       input logic [15:0] addr, input logic [63:0] wd, input logic [7:0] st);
    if (i == 0) begin
      pselA = sel; penA = en; pwrA = wr; paddrA = addr; pwdataA = wd; pstrbA = st;
    end else begin
      pselB = sel; penB = en; pwrB = wr; paddrB = addr; pwdataB = wd[31:0]; pstrbB = st[3:0];
    end
  endtask

  task automatic apb(input int i, input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                     input logic [7:0] st, output logic [63:0] rdOut, output logic slvOut,
                     output logic rdyOut);
    logic [63:0] expRd, data, bm, cur;
    logic [7:0]  mask;
    bit          isMsip, isCmp, isTime, mapped;
    isMsip = (addr[15:3] == 13'h0000);
    isCmp  = (addr[15:3] == 13'h0800);
    isTime = (addr[15:3] == 13'h17FF);
    mapped = isMsip || isCmp || isTime;
    if (i == 0) begin
      mask = st;
      data = wd;
    end else begin
      mask = addr[2] ? {st[3:0], 4'h0} : {4'h0, st[3:0]};
      data = {wd[31:0], wd[31:0]};
    end
    for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{mask[b]}};
    @(posedge clk); #1;
    drive(i, 1'b1, 1'b0, wr, addr, wd, st);
    cur = isMsip ? {63'b0, msipM[i]} : isCmp ? cmpM[i] : isTime ? modelMtime(i) : 64'b0;
    expRd = (i == 0) ? cur : (addr[2] ? {32'b0, cur[63:32]} : {32'b0, cur[31:0]});
    @(posedge clk); #1;
    drive(i, 1'b1, 1'b1, wr, addr, wd, st);
    @(negedge clk);
    rdyOut = (i == 0) ? preadyA : preadyB;
    slvOut = (i == 0) ? pslverrA : pslverrB;
    rdOut  = (i == 0) ? prdataA : {32'b0, prdataB};
    check("pready", 64'(rdyOut), 64'd1);
    check("pslverr", 64'(slvOut), 64'(!mapped));
    if (!wr) check("prdata", rdOut, expRd);
    cur = modelMtime(i);
    @(posedge clk); #1;
    drive(i, 1'b0, 1'b0, 1'b0, addr, wd, st);
    if (wr && mapped) begin
      if (isMsip && mask[0]) msipM[i] = data[0];
      if (isCmp) cmpM[i] = (cmpM[i] & ~bm) | (data & bm);
      if (isTime && mask != 8'h00) begin
        baseM[i]   = (cur & ~bm) | (data & bm);
        baseCyc[i] = cyc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    logic        slv, rdy;
    int          ri, rr;
    logic [15:0] ra;

    rstN = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstPrdataA", prdataA, 64'h0);
    check("rstPreadyA", 64'(preadyA), 64'h0);
    check("rstSlverrB", 64'(pslverrB), 64'h0);
    check("rstMtimeA", mtimeA, 64'h0);
    check("rstTintA", 64'(tintA), 64'h0);
    rstN = 1'b1;
    resetModel();

    // Free-running count after reset.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idleMtimeA", mtimeA, 64'd10);
    check("idleMtimeB", mtimeB, 64'd2);
    check("idleTintA", 64'(tintA), 64'h0);
    check("idleSwA", 64'(swA), 64'h0);

    // Timer compare rise, then fall after raising mtimecmp.
    apb(0, 1'b1, 16'h4000, modelMtime(0) + 64'd12, 8'hFF, rd, slv, rdy);
    tick(20);
    check("tintRisen", 64'(tintA), 64'd1);
    apb(0, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, slv, rdy);
    tick(1);
    check("tintHold", 64'(tintA), 64'd1);
    tick(1);
    check("tintFall", 64'(tintA), 64'd0);

    // Carry across 32-bit halves.
    apb(1, 1'b1, 16'hBFF8, 64'hFFFF_FFFF, 8'hF, rd, slv, rdy);
    apb(1, 1'b1, 16'hBFFC, 64'h0, 8'hF, rd, slv, rdy);
    tick(5);
    check("carryB", mtimeB, 64'h1_0000_0000);
    apb(1, 1'b0, 16'hBFFC, 64'h0, 8'h0, rd, slv, rdy);
    check("carryHiRd", rd, 64'd1);

    // Software interrupt bit.
    apb(0, 1'b1, 16'h0000, 64'hFFFF_FFFF, 8'hFF, rd, slv, rdy);
    tick(1);
    check("msipSet", 64'(swA), 64'd1);
    apb(0, 1'b0, 16'h0000, 64'h0, 8'h0, rd, slv, rdy);
    check("msipRd", rd, 64'd1);
    apb(0, 1'b1, 16'h0000, 64'h0, 8'h00, rd, slv, rdy);
    tick(1);
    check("msipKeep", 64'(swA), 64'd1);

    // Prescaler restart on mtime write.
    tick(2);
    apb(1, 1'b1, 16'hBFF8, 64'd100, 8'hF, rd, slv, rdy);
    apb(1, 1'b1, 16'hBFFC, 64'd0, 8'hF, rd, slv, rdy);
    tick(4);
    check("presc100", mtimeB, 64'd100);
    tick(1);
    check("presc101", mtimeB, 64'd101);

    // Unmapped read.
    apb(0, 1'b0, 16'h2000, 64'h0, 8'h0, rd, slv, rdy);
    check("unmapRd", rd, 64'h0);
    check("unmapErr", 64'(slv), 64'd1);
    check("unmapRdy", 64'(rdy), 64'd1);

    // Reset during a mtimecmp write access.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b1, 16'h4000, 64'h5, 8'hFF);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 16'h4000, 64'h5, 8'hFF);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("midRstReady", 64'(preadyA), 64'h0);
    check("midRstSlv", 64'(pslverrA), 64'h0);
    check("midRstPrdata", prdataA, 64'h0);
    check("midRstMtime", mtimeA, 64'h0);
    check("midRstSw", 64'(swA), 64'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
    @(negedge clk);
    rstN = 1'b1;
    resetModel();
    apb(0, 1'b0, 16'h4000, 64'h0, 8'h0, rd, slv, rdy);
    check("cmpAfterRst", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    apb(1, 1'b0, 16'h4000, 64'h0, 8'h0, rd, slv, rdy);
    check("cmpAfterRstB", rd, 64'hFFFF_FFFF);

    // Random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      ri = $urandom_range(0, 1);
      rr = $urandom_range(0, 3);
      case (rr)
        0:       ra = 16'h0000;
        1:       ra = 16'h4000;
        2:       ra = 16'hBFF8;
        default: ra = 16'h1000 | 16'($urandom_range(0, 16'h0FFF));
      endcase
      ra[2] = 1'($urandom_range(0, 1));
      apb(ri, 1'($urandom_range(0, 1)), ra, {$urandom, $urandom}, 8'($urandom), rd, slv, rdy);
      tick($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
